// File: rtl/lsu_mem_master.sv
`timescale 1ns/1ps
// lsu_mem_master: data-side load/store master for a one-cycle-latency word memory.
// Turns byte-addressed core requests into strobed word writes and returns extended load data.
module lsu_mem_master #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              cpu_rstn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [31:0]       mem_rd_data,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [31:0]       mem_wr_data,
    output logic [3:0]        mem_wr_strobe
);

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef enum logic [1:0] {
        IDLE,
        LD_ADDR,
        LD_DATA,
        ST_WR
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] rdAddr_q, rdAddr_d;
    logic [ADDR_W-1:0] wrAddr_q, wrAddr_d;
    logic [31:0]       wrData_q, wrData_d;
    logic [3:0]        strobe_q, strobe_d;
    logic              respValid_q, respValid_d;
    logic              respErr_q, respErr_d;
    logic [31:0]       respRdata_q, respRdata_d;
    logic [1:0]        ldOff_q, ldOff_d;
    logic [1:0]        ldSize_q, ldSize_d;
    logic              ldUnsigned_q, ldUnsigned_d;

    logic              accept;
    logic              outOfRange;
    logic              reqErr;
    logic [ADDR_W-1:0] reqWordAddr;
    logic [3:0]        stStrobe;
    logic [31:0]       stData;
    logic [31:0]       ldShifted;
    logic [31:0]       ldResult;

    assign req_ready   = (state_q == IDLE);
    assign accept      = req_valid && req_ready;
    assign reqWordAddr = req_addr[ADDR_W+1:2];
    assign outOfRange  = (req_addr >> (ADDR_W + 2)) != 32'd0;
    assign reqErr      = (req_size == 2'd3)
                      || ((req_size == SIZE_HALF) && req_addr[0])
                      || ((req_size == SIZE_WORD) && (req_addr[1:0] != 2'b00))
                      || outOfRange;

    // Store lanes: data is replicated across lanes so the strobe alone picks the target bytes.
    always_comb begin
        stStrobe = 4'b0000;
        stData   = req_wdata;
        case (req_size)
            SIZE_BYTE: begin
                stStrobe = 4'b0001 << req_addr[1:0];
                stData   = {4{req_wdata[7:0]}};
            end
            SIZE_HALF: begin
                stStrobe = req_addr[1] ? 4'b1100 : 4'b0011;
                stData   = {2{req_wdata[15:0]}};
            end
            SIZE_WORD: stStrobe = 4'b1111;
            default:   stStrobe = 4'b0000;
        endcase
    end

    // Loads are aligned, so a single right shift by the byte offset serves every size.
    assign ldShifted = mem_rd_data >> {ldOff_q, 3'b000};

    always_comb begin
        case (ldSize_q)
            SIZE_BYTE: ldResult = ldUnsigned_q ? {24'd0, ldShifted[7:0]}
                                               : {{24{ldShifted[7]}}, ldShifted[7:0]};
            SIZE_HALF: ldResult = ldUnsigned_q ? {16'd0, ldShifted[15:0]}
                                               : {{16{ldShifted[15]}}, ldShifted[15:0]};
            default:   ldResult = ldShifted;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        rdAddr_d     = rdAddr_q;
        wrAddr_d     = wrAddr_q;
        wrData_d     = wrData_q;
        strobe_d     = 4'b0000;
        respValid_d  = 1'b0;
        respErr_d    = 1'b0;
        respRdata_d  = 32'd0;
        ldOff_d      = ldOff_q;
        ldSize_d     = ldSize_q;
        ldUnsigned_d = ldUnsigned_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (reqErr) begin
                        respValid_d = 1'b1;
                        respErr_d   = 1'b1;
                    end else if (req_we) begin
                        state_d  = ST_WR;
                        wrAddr_d = reqWordAddr;
                        wrData_d = stData;
                        strobe_d = stStrobe;
                    end else begin
                        state_d      = LD_ADDR;
                        rdAddr_d     = reqWordAddr;
                        ldOff_d      = req_addr[1:0];
                        ldSize_d     = req_size;
                        ldUnsigned_d = req_unsigned;
                    end
                end
            end
            LD_ADDR: state_d = LD_DATA;
            LD_DATA: begin
                state_d     = IDLE;
                respValid_d = 1'b1;
                respRdata_d = ldResult;
            end
            ST_WR: begin
                state_d     = IDLE;
                respValid_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Async reset drops the strobe and any pending response immediately, discarding the request.
    always_ff @(posedge clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            state_q      <= IDLE;
            rdAddr_q     <= '0;
            wrAddr_q     <= '0;
            wrData_q     <= 32'd0;
            strobe_q     <= 4'b0000;
            respValid_q  <= 1'b0;
            respErr_q    <= 1'b0;
            respRdata_q  <= 32'd0;
            ldOff_q      <= 2'd0;
            ldSize_q     <= 2'd0;
            ldUnsigned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rdAddr_q     <= rdAddr_d;
            wrAddr_q     <= wrAddr_d;
            wrData_q     <= wrData_d;
            strobe_q     <= strobe_d;
            respValid_q  <= respValid_d;
            respErr_q    <= respErr_d;
            respRdata_q  <= respRdata_d;
            ldOff_q      <= ldOff_d;
            ldSize_q     <= ldSize_d;
            ldUnsigned_q <= ldUnsigned_d;
        end
    end

    assign mem_rd_addr   = rdAddr_q;
    assign mem_wr_addr   = wrAddr_q;
    assign mem_wr_data   = wrData_q;
    assign mem_wr_strobe = strobe_q;
    assign resp_valid    = respValid_q;
    assign resp_err      = respErr_q;
    assign resp_rdata    = respRdata_q;

endmodule

// File: tb/tb_lsu_mem_master.sv
`timescale 1ns/1ps
// tb_lsu_mem_master: randomized scoreboard bench for lsu_mem_master against a byte-array memory model.
// The driver pushes expected responses/writes at acceptance; a negedge monitor pops and compares.
module tb_lsu_mem_master;

    localparam int ADDR_W = 8;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int BYTES  = 4 * DEPTH;

    logic              clk;
    logic              cpu_rstn;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic [31:0]       memRdData;
    logic [ADDR_W-1:0] mem_wr_addr;
    logic [31:0]       mem_wr_data;
    logic [3:0]        mem_wr_strobe;

    lsu_mem_master #(.ADDR_W(ADDR_W)) dut (
        .clk           (clk),
        .cpu_rstn      (cpu_rstn),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_we        (req_we),
        .req_size      (req_size),
        .req_unsigned  (req_unsigned),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .resp_valid    (resp_valid),
        .resp_rdata    (resp_rdata),
        .resp_err      (resp_err),
        .mem_rd_addr   (mem_rd_addr),
        .mem_rd_data   (memRdData),
        .mem_wr_addr   (mem_wr_addr),
        .mem_wr_data   (mem_wr_data),
        .mem_wr_strobe (mem_wr_strobe)
    );

    typedef struct {
        int          cycle;
        logic        err;
        logic [31:0] rdata;
        logic        isStore;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          nbytes;
    } respT;

    typedef struct {
        int          cycle;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [3:0]  strobe;
    } wrT;

    respT        respQ[$];
    wrT          wrQ[$];
    int          checks = 0;
    int          errors = 0;
    int          cycleCount = 0;
    int          readyCycle = 0;
    logic [7:0]  expRdAddr = 8'd0;
    logic [7:0]  refBytes [0:BYTES-1];
    bit          written [0:BYTES-1];
    logic [31:0] tbMem [0:DEPTH-1];
    bit          memLoaded = 1'b0;
    respT        monResp;
    wrT          monWr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycleCount <= cycleCount + 1;

    function automatic logic [31:0] seedWord(input int i);
        return (i * 32'h9E3779B1) ^ 32'hC3A55A3C;
    endfunction

    function automatic logic [7:0] seedByte(input int a);
        logic [31:0] w;
        w = seedWord(a / 4) >> (8 * (a % 4));
        return w[7:0];
    endfunction

    function automatic logic [7:0] modelByte(input int a);
        return written[a] ? refBytes[a] : seedByte(a);
    endfunction

    function automatic int sizeBytes(input logic [1:0] size);
        case (size)
            2'd0:    return 1;
            2'd1:    return 2;
            2'd2:    return 4;
            default: return 0;
        endcase
    endfunction

    // Word-wide memory with one-cycle read latency, contents seeded from seedWord.
    always @(posedge clk) begin
        if (!memLoaded) begin
            for (int i = 0; i < DEPTH; i++) tbMem[i] <= seedWord(i);
            memLoaded <= 1'b1;
        end else begin
            for (int i = 0; i < 4; i++)
                if (mem_wr_strobe[i]) tbMem[mem_wr_addr][8*i +: 8] <= mem_wr_data[8*i +: 8];
        end
        memRdData <= tbMem[mem_rd_addr];
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", name, actual, expected, cycleCount);
        end
    endtask

    // Monitor: compares whatever the DUT presents against the cycle-tagged expectations.
    always @(negedge clk) begin
        if (!cpu_rstn) begin
            respQ.delete();
            wrQ.delete();
        end else begin
            checkOutput("ready", {31'd0, req_ready}, (cycleCount >= readyCycle) ? 32'd1 : 32'd0);
            checkOutput("rd_addr", {24'd0, mem_rd_addr}, {24'd0, expRdAddr});
            if (respQ.size() > 0 && respQ[0].cycle == cycleCount) begin
                monResp = respQ.pop_front();
                checkOutput("resp_valid", {31'd0, resp_valid}, 32'd1);
                checkOutput("resp_err", {31'd0, resp_err}, {31'd0, monResp.err});
                checkOutput("resp_rdata", resp_rdata, monResp.rdata);
                if (monResp.isStore && !monResp.err) begin
                    for (int k = 0; k < monResp.nbytes; k++) begin
                        refBytes[int'(monResp.addr[9:0]) + k] = monResp.wdata[8*k +: 8];
                        written[int'(monResp.addr[9:0]) + k]  = 1'b1;
                    end
                end
            end else begin
                checkOutput("no_resp", {31'd0, resp_valid}, 32'd0);
            end
            if (wrQ.size() > 0 && wrQ[0].cycle == cycleCount) begin
                monWr = wrQ.pop_front();
                checkOutput("wr_strobe", {28'd0, mem_wr_strobe}, {28'd0, monWr.strobe});
                checkOutput("wr_addr", {24'd0, mem_wr_addr}, {24'd0, monWr.addr});
                checkOutput("wr_data", mem_wr_data, monWr.data);
            end else begin
                checkOutput("no_strobe", {28'd0, mem_wr_strobe}, 32'd0);
            end
        end
    end

    // Reference model: decides error/store/load outcome from byte-level rules at acceptance.
    task automatic recordAccept(input int c, input logic we, input logic [1:0] size, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wdata);
        respT r;
        wrT   w;
        int   n;
        int   off;
        logic [31:0] v;
        n = sizeBytes(size);
        r.isStore = we;
        r.addr    = addr;
        r.wdata   = wdata;
        r.nbytes  = n;
        r.rdata   = 32'd0;
        r.err     = (n == 0) || (addr >= BYTES) || ((addr % n) != 0);
        if (r.err) begin
            r.cycle    = c + 1;
            readyCycle = c + 1;
        end else if (we) begin
            off      = int'(addr % 4);
            w.cycle  = c + 1;
            w.addr   = 8'(addr / 4);
            w.strobe = 4'b0000;
            w.data   = 32'd0;
            for (int k = 0; k < n; k++) w.strobe[off + k] = 1'b1;
            for (int i = 0; i < 4; i++) w.data[8*i +: 8] = wdata[8*(i % n) +: 8];
            wrQ.push_back(w);
            r.cycle    = c + 2;
            readyCycle = c + 2;
        end else begin
            v = 32'd0;
            for (int k = 0; k < n; k++) v = v | (32'(modelByte(int'(addr) + k)) << (8 * k));
            if (!uns && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
            r.rdata    = v;
            expRdAddr  = 8'(addr / 4);
            r.cycle    = c + 3;
            readyCycle = c + 3;
        end
        respQ.push_back(r);
    endtask

    task automatic applyStimulus(input logic we, input logic [1:0] size, input logic uns,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        int waitCount = 0;
        @(posedge clk);
        #1;
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        @(negedge clk);
        while (!req_ready && waitCount < 20) begin
            @(negedge clk);
            waitCount++;
        end
        if (!req_ready) begin
            checkOutput("accept_timeout", 32'd0, 32'd1);
            req_valid = 1'b0;
        end else begin
            #1;
            recordAccept(cycleCount, we, size, uns, addr, wdata);
        end
    endtask

    task automatic idle(input int n);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (n) @(posedge clk);
    endtask

    task automatic resetDuring(input logic duringStore);
        if (duringStore) applyStimulus(1'b1, 2'd2, 1'b0, 32'h10, 32'hCAFEF00D);
        else             applyStimulus(1'b0, 2'd2, 1'b0, 32'h20, 32'd0);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        if (duringStore) begin
            checkOutput("pre_rst_strobe", {28'd0, mem_wr_strobe}, 32'hF);
            #1;
        end else begin
            @(posedge clk);
            #2;
        end
        cpu_rstn = 1'b0;
        #1;
        checkOutput("mid_rst_strobe", {28'd0, mem_wr_strobe}, 32'd0);
        checkOutput("mid_rst_resp", {31'd0, resp_valid}, 32'd0);
        checkOutput("mid_rst_ready", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        readyCycle = 0;
        expRdAddr  = 8'd0;
        @(negedge clk);
        #1;
        cpu_rstn = 1'b1;
    endtask

    initial begin
        logic [31:0] a;
        logic [1:0]  sz;
        int          n;
        int          r;
        cpu_rstn     = 1'b1;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'd0;
        req_unsigned = 1'b0;
        req_addr     = 32'd0;
        req_wdata    = 32'd0;
        #2;
        cpu_rstn = 1'b0;
        #1;
        checkOutput("rst_ready", {31'd0, req_ready}, 32'd1);
        checkOutput("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        checkOutput("rst_resp_err", {31'd0, resp_err}, 32'd0);
        checkOutput("rst_resp_rdata", resp_rdata, 32'd0);
        checkOutput("rst_strobe", {28'd0, mem_wr_strobe}, 32'd0);
        checkOutput("rst_rd_addr", {24'd0, mem_rd_addr}, 32'd0);
        checkOutput("rst_wr_addr", {24'd0, mem_wr_addr}, 32'd0);
        checkOutput("rst_wr_data", mem_wr_data, 32'd0);
        repeat (3) @(negedge clk);
        #1;
        cpu_rstn = 1'b1;

        applyStimulus(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF);
        applyStimulus(1'b1, 2'd0, 1'b0, 32'h13, 32'h000000A5);
        applyStimulus(1'b0, 2'd0, 1'b0, 32'h13, 32'd0);
        applyStimulus(1'b0, 2'd0, 1'b1, 32'h13, 32'd0);
        applyStimulus(1'b1, 2'd1, 1'b0, 32'h22, 32'h00008001);
        applyStimulus(1'b0, 2'd1, 1'b0, 32'h22, 32'd0);
        applyStimulus(1'b0, 2'd1, 1'b1, 32'h22, 32'd0);
        idle(2);
        applyStimulus(1'b0, 2'd2, 1'b0, 32'h2, 32'd0);
        applyStimulus(1'b0, 2'd1, 1'b0, 32'h1, 32'd0);
        applyStimulus(1'b0, 2'd3, 1'b0, 32'h0, 32'd0);
        applyStimulus(1'b0, 2'd2, 1'b0, 32'h400, 32'd0);
        applyStimulus(1'b1, 2'd2, 1'b0, 32'h0, 32'h13579BDF);
        applyStimulus(1'b0, 2'd2, 1'b0, 32'h0, 32'd0);
        idle(2);

        resetDuring(1'b1);
        applyStimulus(1'b0, 2'd2, 1'b0, 32'h10, 32'd0);
        idle(1);
        resetDuring(1'b0);
        applyStimulus(1'b0, 2'd2, 1'b0, 32'h20, 32'd0);

        for (int i = 0; i < 300; i++) begin
            r  = $urandom_range(0, 99);
            sz = (r < 6) ? 2'd3 : 2'($urandom_range(0, 2));
            n  = sizeBytes(sz);
            if (r >= 6 && r < 12) begin
                a = $urandom;
                if (a < BYTES) a = a | 32'h400;
            end else begin
                a = (r < 60) ? 32'($urandom_range(0, 15) * 4) : 32'($urandom_range(0, DEPTH - 1) * 4);
                if (r >= 12 && r < 20) a = a + 32'($urandom_range(0, 3));
                else if (n == 1) a = a + 32'($urandom_range(0, 3));
                else if (n == 2) a = a + 32'($urandom_range(0, 1) * 2);
            end
            applyStimulus(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(0, 3));
        end

        idle(10);
        checkOutput("queue_drain", respQ.size() + wrQ.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
